// File: rtl/player_motion.sv
// rtl/player_motion.sv - N-channel per-frame sprite motion controller with jump physics
// Optional double jump: define PLAYER_MOTION_DOUBLE_JUMP_EN.
module player_motion #(
  parameter int N_PLAYERS = 2,
  parameter int XW        = 10,
  parameter int YW        = 10,
  parameter int X_MIN     = 0,
  parameter int X_MAX     = 736,
  parameter int Y_GROUND  = 500,
  parameter int X_START   = 100,
  parameter int X_SPACING = 200,
  parameter int SPEED     = 4,
  parameter int JUMP_V0   = 16,
  parameter int GRAVITY   = 1,
  parameter int VMAX      = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    frame_tick,
  input  logic [N_PLAYERS-1:0]    left,
  input  logic [N_PLAYERS-1:0]    right,
  input  logic [N_PLAYERS-1:0]    jump,
  output logic [N_PLAYERS*XW-1:0] x,
  output logic [N_PLAYERS*YW-1:0] y,
  output logic [N_PLAYERS-1:0]    airborne,
  output logic [N_PLAYERS-1:0]    facing_left
);

  localparam int VPEAK = (JUMP_V0 > VMAX) ? JUMP_V0 : VMAX;
  localparam int VW    = $clog2(VPEAK + 1);

  // Constants pre-sized to the arithmetic widths they are used at.
  localparam logic [XW:0]   XMIN_E = (XW+1)'(X_MIN);
  localparam logic [XW:0]   XMAX_E = (XW+1)'(X_MAX);
  localparam logic [XW:0]   SPD_E  = (XW+1)'(SPEED);
  localparam logic [YW:0]   YG_E   = (YW+1)'(Y_GROUND);
  localparam logic [VW:0]   GRAV_E = (VW+1)'(GRAVITY);
  localparam logic [VW:0]   VMAX_E = (VW+1)'(VMAX);
  localparam logic [VW-1:0] V0_V   = VW'(JUMP_V0);
  localparam logic [VW-1:0] GRAV_V = VW'(GRAVITY);

  typedef enum logic [1:0] {GROUND, RISE, FALL} vstate_t;

  for (genvar i = 0; i < N_PLAYERS; i++) begin : g_ch
    localparam int XR_RAW = X_START + i * X_SPACING;
    localparam int XR     = (XR_RAW < X_MIN) ? X_MIN : ((XR_RAW > X_MAX) ? X_MAX : XR_RAW);

    vstate_t       st_q, st_n;
    logic [XW-1:0] x_q, x_n;
    logic [YW-1:0] y_q, y_n;
    logic [VW-1:0] vy_q, vy_n;
    logic          arm_q, arm_n;
    logic          fl_q, fl_n;
    logic          air_q;
`ifdef PLAYER_MOTION_DOUBLE_JUMP_EN
    logic          dj_q, dj_n;
`endif

    // Widened intermediates so saturation decisions never see a wrapped value.
    logic [XW:0]   x_add;
    logic [VW:0]   v_add;
    logic [VW-1:0] v_fall;
    logic [YW:0]   y_fall;
    logic [YW:0]   vy_y;

    assign x_add  = {1'b0, x_q} + SPD_E;
    assign v_add  = {1'b0, vy_q} + GRAV_E;
    assign v_fall = (v_add > VMAX_E) ? VMAX_E[VW-1:0] : v_add[VW-1:0];
    assign y_fall = {1'b0, y_q} + (YW+1)'(v_fall);
    assign vy_y   = (YW+1)'(vy_q);

    // Next-state: horizontal clamp, vertical FSM and jump re-arm, only on frame ticks.
    always_comb begin
      st_n  = st_q;
      x_n   = x_q;
      y_n   = y_q;
      vy_n  = vy_q;
      arm_n = arm_q;
      fl_n  = fl_q;
`ifdef PLAYER_MOTION_DOUBLE_JUMP_EN
      dj_n  = dj_q;
`endif
      if (frame_tick) begin
        if (left[i] && !right[i]) begin
          x_n  = ({1'b0, x_q} >= XMIN_E + SPD_E) ? (x_q - SPD_E[XW-1:0]) : XMIN_E[XW-1:0];
          fl_n = 1'b1;
        end else if (right[i] && !left[i]) begin
          x_n  = (x_add >= XMAX_E) ? XMAX_E[XW-1:0] : x_add[XW-1:0];
          fl_n = 1'b0;
        end

`ifdef PLAYER_MOTION_DOUBLE_JUMP_EN
        if (st_q != GROUND && jump[i] && arm_q && !dj_q) begin
          st_n  = RISE;
          vy_n  = V0_V;
          arm_n = 1'b0;
          dj_n  = 1'b1;
        end else
`endif
        case (st_q)
          GROUND: begin
            if (jump[i] && arm_q) begin
              st_n  = RISE;
              vy_n  = V0_V;
              arm_n = 1'b0;
            end
          end
          RISE: begin
            if ({1'b0, y_q} < vy_y) begin
              // Would cross the top edge: pin to row 0 and start falling.
              y_n  = '0;
              vy_n = '0;
              st_n = FALL;
            end else begin
              y_n = y_q - vy_y[YW-1:0];
              if (vy_q <= GRAV_V) begin
                vy_n = '0;
                st_n = FALL;
              end else begin
                vy_n = vy_q - GRAV_V;
              end
            end
          end
          FALL: begin
            if (y_fall >= YG_E) begin
              y_n  = YG_E[YW-1:0];
              vy_n = '0;
              st_n = GROUND;
`ifdef PLAYER_MOTION_DOUBLE_JUMP_EN
              dj_n = 1'b0;
`endif
            end else begin
              y_n  = y_fall[YW-1:0];
              vy_n = v_fall;
            end
          end
          default: st_n = GROUND;
        endcase

        // Releasing the key re-arms in every state, so a held key jumps once.
        if (!jump[i]) arm_n = 1'b1;
      end
    end

    // State register with asynchronous return to the spawn point.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        st_q  <= GROUND;
        x_q   <= XW'(XR);
        y_q   <= YW'(Y_GROUND);
        vy_q  <= '0;
        arm_q <= 1'b1;
        fl_q  <= 1'b0;
        air_q <= 1'b0;
`ifdef PLAYER_MOTION_DOUBLE_JUMP_EN
        dj_q  <= 1'b0;
`endif
      end else begin
        st_q  <= st_n;
        x_q   <= x_n;
        y_q   <= y_n;
        vy_q  <= vy_n;
        arm_q <= arm_n;
        fl_q  <= fl_n;
        air_q <= (st_n != GROUND);
`ifdef PLAYER_MOTION_DOUBLE_JUMP_EN
        dj_q  <= dj_n;
`endif
      end
    end

    assign x[i*XW +: XW]  = x_q;
    assign y[i*YW +: YW]  = y_q;
    assign airborne[i]    = air_q;
    assign facing_left[i] = fl_q;
  end

endmodule

// File: tb/tb_player_motion.sv
// tb/tb_player_motion.sv - directed self-checking bench for player_motion
module tb_player_motion;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        frame_tick = 1'b0;
  logic [1:0]  left = '0, right = '0, jump = '0;
  logic [19:0] x, y;
  logic [1:0]  airborne, facing_left;

  int n_vec = 0;
  int n_err = 0;

  player_motion dut (
    .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick),
    .left(left), .right(right), .jump(jump),
    .x(x), .y(y), .airborne(airborne), .facing_left(facing_left)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Called on a falling edge; one frame tick captured at the next rising edge.
  task automatic tick();
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_x0", x[9:0], 100);
    chk("rst_x1", x[19:10], 300);
    chk("rst_y0", y[9:0], 500);
    chk("rst_y1", y[19:10], 500);
    chk("rst_air", airborne, 2'b00);
    chk("rst_face", facing_left, 2'b00);

    // Idle ticks change nothing
    rst_n = 1'b1;
    @(negedge clk);
    ticks(5);
    chk("idle_x0", x[9:0], 100);
    chk("idle_x1", x[19:10], 300);
    chk("idle_y", y, {10'd500, 10'd500});
    chk("idle_air", airborne, 2'b00);

    // No tick means no motion even with keys held
    right = 2'b01;
    repeat (3) @(negedge clk);
    chk("notick_x0", x[9:0], 100);

    // Move right to the wall
    for (int k = 1; k <= 200; k++) begin
      tick();
      if (k == 1)   chk("r1_x0", x[9:0], 104);
      if (k == 158) chk("r158_x0", x[9:0], 732);
      if (k == 159) chk("r159_x0", x[9:0], 736);
    end
    chk("r200_x0", x[9:0], 736);
    chk("r200_x1", x[19:10], 300);
    chk("r200_face", facing_left, 2'b00);

    // Both keys: hold
    left = 2'b01;
    ticks(3);
    chk("lr_x0", x[9:0], 736);
    chk("lr_face0", facing_left[0], 1'b0);

    // Left only
    right = 2'b00;
    tick();
    chk("l1_x0", x[9:0], 732);
    chk("l1_face0", facing_left[0], 1'b1);
    left = 2'b00;

    // Single jump on channel 1
    jump = 2'b10;
    tick();
    jump = 2'b00;
    chk("j1_start_y1", y[19:10], 500);
    chk("j1_start_air", airborne, 2'b10);
    tick();
    chk("j1_t1_y1", y[19:10], 484);
    ticks(15);
    chk("j1_apex_y1", y[19:10], 364);
    chk("j1_apex_air", airborne, 2'b10);
    ticks(15);
    chk("j1_pre_y1", y[19:10], 484);
    chk("j1_pre_air", airborne, 2'b10);
    tick();
    chk("j1_land_y1", y[19:10], 500);
    chk("j1_land_air", airborne, 2'b00);
    chk("j1_ch0_x", x[9:0], 732);
    chk("j1_ch0_y", y[9:0], 500);

    // Held jump on channel 0: exactly one jump
    jump = 2'b01;
    for (int k = 1; k <= 60; k++) begin
      tick();
      if (k == 1)  chk("h_t1_air0", airborne[0], 1'b1);
      if (k == 17) chk("h_apex_y0", y[9:0], 364);
      if (k == 33) chk("h_land_y0", y[9:0], 500);
      if (k == 33) chk("h_land_air0", airborne[0], 1'b0);
    end
    chk("h_t60_y0", y[9:0], 500);
    chk("h_t60_air", airborne, 2'b00);
    jump = 2'b00;
    tick();
    chk("rearm_air", airborne, 2'b00);
    jump = 2'b01;
    tick();
    chk("rejump_air0", airborne[0], 1'b1);
    chk("rejump_y0", y[9:0], 500);
    jump = 2'b00;
    ticks(8);
    chk("mid_y0", y[9:0], 400);

    // Asynchronous reset mid-rise, away from any rising edge
    #2 rst_n = 1'b0;
    #1;
    chk("arst_y0", y[9:0], 500);
    chk("arst_air", airborne, 2'b00);
    chk("arst_x0", x[9:0], 100);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Second press at apex
    jump = 2'b01;
    tick();
    jump = 2'b00;
    ticks(16);
    chk("dj_apex1_y0", y[9:0], 364);
    jump = 2'b01;
    tick();
    jump = 2'b00;
`ifdef PLAYER_MOTION_DOUBLE_JUMP_EN
    chk("dj_press_y0", y[9:0], 364);
    chk("dj_press_air", airborne[0], 1'b1);
    ticks(16);
    chk("dj_apex2_y0", y[9:0], 228);
    jump = 2'b01;
    tick();
    jump = 2'b00;
    chk("dj_third_y0", y[9:0], 229);
    ticks(23);
    chk("dj_fall_y0", y[9:0], 492);
    chk("dj_fall_air", airborne[0], 1'b1);
    tick();
    chk("dj_land_y0", y[9:0], 500);
    chk("dj_land_air", airborne[0], 1'b0);
`else
    chk("sj_press_y0", y[9:0], 365);
    chk("sj_press_air", airborne[0], 1'b1);
    ticks(14);
    chk("sj_pre_y0", y[9:0], 484);
    tick();
    chk("sj_land_y0", y[9:0], 500);
    chk("sj_land_air", airborne[0], 1'b0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
